// File: rtl/twiddle_pkg.sv
// Shared helpers for the twiddle-factor generator: width calculation and
// elaboration-time generation of the quarter-wave cosine table.
package twiddle_pkg;

    localparam int LOG2N_DEF = 6;
    localparam int FRAC_DEF  = 8;
    localparam int QN        = (1 << LOG2N_DEF) / 4;
    localparam int ONE       = 1 << FRAC_DEF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // trunc(cos(2*pi*m/N) * 2^frac), m in 0..N/4. Past the octant the sine
    // series of the complementary angle is used so both series stay in [0, pi/4].
    function automatic int build_cos_q(input int m, input int log2n, input int frac);
        real pi_2;
        real x;
        real term;
        real acc;
        real scale;
        int  qn_l;
        bit  use_sin;
        qn_l    = 1 << (log2n - 2);
        pi_2    = 1.5707963267948966;
        use_sin = (2 * m > qn_l);
        x       = use_sin ? pi_2 * real'(qn_l - m) / real'(qn_l)
                          : pi_2 * real'(m) / real'(qn_l);
        term    = use_sin ? x : 1.0;
        acc     = term;
        for (int unsigned n = 1; n < 12; n++) begin
            if (use_sin)
                term = -term * x * x / real'((2 * n) * (2 * n + 1));
            else
                term = -term * x * x / real'((2 * n - 1) * (2 * n));
            acc = acc + term;
        end
        scale = 1.0;
        for (int unsigned b = 0; b < int'(frac); b++) scale = scale * 2.0;
        return $rtoi(acc * scale);
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM, (N/4+1) entries, two independent registered read ports.
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter  int LOG2N  = 6,
    parameter  int DATA_W = 16,
    parameter  int FRAC   = 8,
    localparam int AW     = LOG2N - 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr_a,
    input  logic [AW-1:0]     addr_b,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b
);

    localparam int ENTRIES = (1 << (LOG2N - 2)) + 1;

    logic [DATA_W-1:0] tab [ENTRIES];
    logic [DATA_W-1:0] dout_a_d, dout_a_q;
    logic [DATA_W-1:0] dout_b_d, dout_b_q;

    for (genvar m = 0; m < ENTRIES; m++) begin : g_tab
        localparam int VAL = build_cos_q(m, LOG2N, FRAC);
        assign tab[m] = DATA_W'(VAL);
    end

    always_comb begin
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        if (en) begin
            dout_a_d = tab[addr_a];
            dout_b_d = tab[addr_b];
        end
    end

    always_ff @(posedge clk) begin
        dout_a_q <= dout_a_d;
        dout_b_q <= dout_b_d;
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;

endmodule

// File: rtl/twiddle_gen.sv
// Radix-2 FFT/IFFT twiddle generator: index fold (P1), quarter-wave ROM read (P2),
// sign application (P3), with a single whole-pipeline stall on output back-pressure.
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter  int LOG2N  = 6,
    parameter  int DATA_W = 16,
    parameter  int FRAC   = 8,
    localparam int STG_W  = clog2(LOG2N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STG_W-1:0]  in_stage,
    input  logic [LOG2N-2:0]  in_idx,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_err
);

    localparam int AW = LOG2N - 1;
    localparam int IW = LOG2N - 1;
    localparam int RW = LOG2N - 2;
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N - 1);
    localparam logic [AW-1:0]    QN_A     = AW'(1 << RW);

    logic              adv;
    logic              err_c;
    logic [STG_W-1:0]  s_eff;
    logic [STG_W-1:0]  shamt;
    logic [IW-1:0]     mask;
    logic [LOG2N-1:0]  k;
    logic [1:0]        q;
    logic [AW-1:0]     r_ext, r_cmp;

    logic              v1_d, v1_q;
    logic [AW-1:0]     addr_a_d, addr_a_q, addr_b_d, addr_b_q;
    logic              neg_re1_d, neg_re1_q, neg_im1_d, neg_im1_q, err1_d, err1_q;
    logic              v2_d, v2_q;
    logic              neg_re2_d, neg_re2_q, neg_im2_d, neg_im2_q, err2_d, err2_q;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              out_valid_d, out_valid_q, out_err_d, out_err_q;
    logic [DATA_W-1:0] out_re_d, out_re_q, out_im_d, out_im_q;

    assign adv = ~out_valid_q | out_ready;

    always_comb begin
        err_c = (in_stage > LAST_STG);
        s_eff = err_c ? LAST_STG : in_stage;
        shamt = LAST_STG - s_eff;
        mask  = IW'((1 << s_eff) - 1);
        k     = {1'b0, in_idx & mask} << shamt;
        q     = k[LOG2N-1 -: 2];
        r_ext = {1'b0, k[RW-1:0]};
        r_cmp = QN_A - r_ext;
    end

    // Odd quadrants swap the cos/sin table addresses; sign flags fold in the
    // quadrant and the forward/inverse choice so P3 is a pure conditional negate.
    always_comb begin
        v1_d      = adv ? in_valid : v1_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        neg_re1_d = neg_re1_q;
        neg_im1_d = neg_im1_q;
        err1_d    = err1_q;
        if (adv && in_valid) begin
            addr_a_d  = q[0] ? r_cmp : r_ext;
            addr_b_d  = q[0] ? r_ext : r_cmp;
            neg_re1_d = q[1] ^ q[0];
            neg_im1_d = q[1] ^ ~in_inv;
            err1_d    = err_c;
        end
    end

    always_comb begin
        v2_d      = adv ? v1_q : v2_q;
        neg_re2_d = neg_re2_q;
        neg_im2_d = neg_im2_q;
        err2_d    = err2_q;
        if (adv && v1_q) begin
            neg_re2_d = neg_re1_q;
            neg_im2_d = neg_im1_q;
            err2_d    = err1_q;
        end
    end

    twiddle_qrom #(.LOG2N(LOG2N), .DATA_W(DATA_W), .FRAC(FRAC)) u_qrom (
        .clk    (clk),
        .en     (adv & v1_q),
        .addr_a (addr_a_q),
        .addr_b (addr_b_q),
        .dout_a (rd_a),
        .dout_b (rd_b)
    );

    always_comb begin
        out_valid_d = adv ? v2_q : out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_err_d   = out_err_q;
        if (adv && v2_q) begin
            out_re_d  = neg_re2_q ? -rd_a : rd_a;
            out_im_d  = neg_im2_q ? -rd_b : rd_b;
            out_err_d = err2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_err_q   <= out_err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_a_q  <= addr_a_d;
        addr_b_q  <= addr_b_d;
        neg_re1_q <= neg_re1_d;
        neg_im1_q <= neg_im1_d;
        err1_q    <= err1_d;
        neg_re2_q <= neg_re2_d;
        neg_im2_q <= neg_im2_d;
        err2_q    <= err2_d;
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_err   = out_err_q;

endmodule
